// File: rtl/fetcher.sv
// Instruction fetcher: walks the pc, looks up an optional direct-mapped
// instruction cache, requests misses from the memory controller, and
// delivers one instruction per hit/refill to the dispatcher with the
// branch predictor's decision attached.
// Optional feature macro: ICACHE_EN (defined = cache present; undefined =
// no cache storage, every lookup misses and goes to memory).
module fetcher #(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int          ICACHE_LINES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        full_from_iq,
  output logic        ena_to_mc,
  output logic [31:0] addr_to_mc,
  input  logic        ok_flag_from_mc,
  input  logic [31:0] inst_from_mc,
  output logic [31:0] query_pc,
  output logic [31:0] query_inst,
  input  logic        predicted_jump,
  input  logic [31:0] predicted_imm,
  output logic        ok_flag_to_dsp,
  output logic [31:0] inst_to_dsp,
  output logic [31:0] pc_to_dsp,
  output logic        predicted_jump_to_dsp,
  input  logic        rollback_from_rob,
  input  logic [31:0] target_pc_from_rob
);

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT_MEM = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        ena_q, ena_d;
  logic [31:0] addr_q, addr_d;
  logic        ok_q, ok_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] dpc_q, dpc_d;
  logic        pj_q, pj_d;
  logic        hit_s;
  logic [31:0] hit_word_s;

`ifdef ICACHE_EN
  localparam int IDX_W = $clog2(ICACHE_LINES);
  localparam int TAG_W = 32 - IDX_W - 2;

  logic             valid_q [ICACHE_LINES];
  logic [TAG_W-1:0] tag_q   [ICACHE_LINES];
  logic [31:0]      data_q  [ICACHE_LINES];
  logic [IDX_W-1:0] rd_idx_s;
  logic [IDX_W-1:0] wr_idx_s;
  logic             fill_s;

  // Lookup uses the current pc; refill uses the address held on the bus,
  // which stays valid even when a rollback lands on the same cycle.
  assign rd_idx_s   = pc_q[IDX_W+1:2];
  assign wr_idx_s   = addr_q[IDX_W+1:2];
  assign fill_s     = (state_q == WAIT_MEM) && ok_flag_from_mc;
  assign hit_s      = valid_q[rd_idx_s] && (tag_q[rd_idx_s] == pc_q[31:IDX_W+2]);
  assign hit_word_s = data_q[rd_idx_s];

  // Valid bits: cleared by reset, set when a memory response arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ICACHE_LINES; i++) valid_q[i] <= 1'b0;
    end else if (fill_s) begin
      valid_q[wr_idx_s] <= 1'b1;
    end
  end

  // Tag and data storage: written on refill only, no reset needed.
  always_ff @(posedge clk) begin
    if (fill_s) begin
      tag_q[wr_idx_s]  <= addr_q[31:IDX_W+2];
      data_q[wr_idx_s] <= inst_from_mc;
    end
  end
`else
  assign hit_s      = 1'b0;
  assign hit_word_s = 32'h0;
`endif

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ena_q   <= 1'b0;
      addr_q  <= 32'h0;
      ok_q    <= 1'b0;
      inst_q  <= 32'h0;
      dpc_q   <= 32'h0;
      pj_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ena_q   <= ena_d;
      addr_q  <= addr_d;
      ok_q    <= ok_d;
      inst_q  <= inst_d;
      dpc_q   <= dpc_d;
      pj_q    <= pj_d;
    end
  end

  // Next-state logic: rollback wins, then hit delivery, miss request or
  // refill delivery. A delivery registers the dispatch outputs and
  // advances pc along the predicted path.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ena_d      = ena_q;
    addr_d     = addr_q;
    ok_d       = 1'b0;
    inst_d     = inst_q;
    dpc_d      = dpc_q;
    pj_d       = pj_q;
    query_inst = 32'h0;
    if (rollback_from_rob) begin
      state_d = IDLE;
      pc_d    = target_pc_from_rob;
      ena_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!full_from_iq) begin
            if (hit_s) begin
              query_inst = hit_word_s;
            end else begin
              ena_d   = 1'b1;
              addr_d  = pc_q;
              state_d = WAIT_MEM;
            end
          end else begin
            state_d = IDLE;
          end
        end
        WAIT_MEM: begin
          // A pending refill completes even if the queue reports full.
          if (ok_flag_from_mc) begin
            query_inst = inst_from_mc;
            ena_d      = 1'b0;
            state_d    = IDLE;
          end else begin
            state_d = WAIT_MEM;
          end
        end
        default: begin
          state_d = IDLE;
          ena_d   = 1'b0;
        end
      endcase
      if ((state_q == IDLE && !full_from_iq && hit_s) ||
          (state_q == WAIT_MEM && ok_flag_from_mc)) begin
        ok_d   = 1'b1;
        inst_d = query_inst;
        dpc_d  = pc_q;
        pj_d   = predicted_jump;
        pc_d   = predicted_jump ? (pc_q + predicted_imm) : (pc_q + 32'd4);
      end else begin
        ok_d = 1'b0;
      end
    end
  end

  assign query_pc              = pc_q;
  assign ena_to_mc             = ena_q;
  assign addr_to_mc            = addr_q;
  assign ok_flag_to_dsp        = ok_q;
  assign inst_to_dsp           = inst_q;
  assign pc_to_dsp             = dpc_q;
  assign predicted_jump_to_dsp = pj_q;

endmodule

// File: tb/tb_fetcher.sv
// Directed testbench for fetcher. Expectations are hand-derived; the
// branch predictor is a small JAL decoder driven from query_inst.
// Build with or without ICACHE_EN; rollback-to-cached-pc expectations
// differ between the two builds.
module tb_fetcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        full_from_iq;
  logic        ena_to_mc;
  logic [31:0] addr_to_mc;
  logic        ok_flag_from_mc;
  logic [31:0] inst_from_mc;
  logic [31:0] query_pc;
  logic [31:0] query_inst;
  logic        predicted_jump;
  logic [31:0] predicted_imm;
  logic        ok_flag_to_dsp;
  logic [31:0] inst_to_dsp;
  logic [31:0] pc_to_dsp;
  logic        predicted_jump_to_dsp;
  logic        rollback_from_rob;
  logic [31:0] target_pc_from_rob;

  int n_checks = 0;
  int n_fail   = 0;

  fetcher dut (
    .clk                   (clk),
    .rst                   (rst),
    .full_from_iq          (full_from_iq),
    .ena_to_mc             (ena_to_mc),
    .addr_to_mc            (addr_to_mc),
    .ok_flag_from_mc       (ok_flag_from_mc),
    .inst_from_mc          (inst_from_mc),
    .query_pc              (query_pc),
    .query_inst            (query_inst),
    .predicted_jump        (predicted_jump),
    .predicted_imm         (predicted_imm),
    .ok_flag_to_dsp        (ok_flag_to_dsp),
    .inst_to_dsp           (inst_to_dsp),
    .pc_to_dsp             (pc_to_dsp),
    .predicted_jump_to_dsp (predicted_jump_to_dsp),
    .rollback_from_rob     (rollback_from_rob),
    .target_pc_from_rob    (target_pc_from_rob)
  );

  always #5 clk = ~clk;

  // Predictor model: JAL is predicted taken with its J-type offset.
  always_comb begin
    predicted_jump = (query_inst[6:0] == 7'b1101111);
    predicted_imm  = {{12{query_inst[31]}}, query_inst[19:12], query_inst[20],
                      query_inst[30:21], 1'b0};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_req(input string tag, input logic ena, input logic [31:0] addr);
    check({tag, ".ena"}, {31'h0, ena_to_mc}, {31'h0, ena});
    if (ena) check({tag, ".addr"}, addr_to_mc, addr);
  endtask

  task automatic check_dsp(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                           input logic pj);
    check({tag, ".ok"},   {31'h0, ok_flag_to_dsp}, 32'h1);
    check({tag, ".inst"}, inst_to_dsp, inst);
    check({tag, ".pc"},   pc_to_dsp, pc);
    check({tag, ".pj"},   {31'h0, predicted_jump_to_dsp}, {31'h0, pj});
  endtask

  // Serve the pending request with one ok pulse, then check the delivery.
  task automatic serve(input string tag, input logic [31:0] word, input logic [31:0] pc,
                       input logic pj);
    ok_flag_from_mc = 1'b1;
    inst_from_mc    = word;
    #1;
    check({tag, ".qinst"}, query_inst, word);
    step();
    ok_flag_from_mc = 1'b0;
    check_dsp(tag, word, pc, pj);
  endtask

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] JAL = 32'h0080006F;

  initial begin
    rst = 1'b1; full_from_iq = 1'b0; ok_flag_from_mc = 1'b0; inst_from_mc = 32'h0;
    rollback_from_rob = 1'b0; target_pc_from_rob = 32'h0;
    step(); step();
    check_req("rst", 1'b0, 32'h0);
    check("rst.addr", addr_to_mc, 32'h0);
    check("rst.ok", {31'h0, ok_flag_to_dsp}, 32'h0);
    check("rst.inst", inst_to_dsp, 32'h0);
    check("rst.pc", pc_to_dsp, 32'h0);
    check("rst.qpc", query_pc, 32'h0);

    // First fetch at reset pc, then sequential fetch at 0x4.
    rst = 1'b0;
    step();
    check_req("req0", 1'b1, 32'h0);
    serve("d0", NOP, 32'h0, 1'b0);
    check("d0.qpc", query_pc, 32'h4);
    check_req("d0.ena", 1'b0, 32'h0);
    step();
    check_req("req4", 1'b1, 32'h4);
    step();
    check_req("req4.hold", 1'b1, 32'h4);
    check("req4.nook", {31'h0, ok_flag_to_dsp}, 32'h0);
    serve("d4", JAL, 32'h4, 1'b1);
    check("d4.qpc", query_pc, 32'hC);
    check("d4.once", {31'h0, ok_flag_to_dsp}, 32'h1);
    step();
    check("d4.pulse", {31'h0, ok_flag_to_dsp}, 32'h0);
    check_req("reqC", 1'b1, 32'hC);

    // Rollback to 0x0 while waiting on 0xC.
    rollback_from_rob = 1'b1; target_pc_from_rob = 32'h0;
    step();
    rollback_from_rob = 1'b0;
    check_req("rb0", 1'b0, 32'h0);
    check("rb0.ok", {31'h0, ok_flag_to_dsp}, 32'h0);
    check("rb0.qpc", query_pc, 32'h0);
`ifdef ICACHE_EN
    check("rb0.hit", query_inst, NOP);
    step();
    check_dsp("rb0.d0", NOP, 32'h0, 1'b0);
    check_req("rb0.d0", 1'b0, 32'h0);
    step();
    check_dsp("rb0.d4", JAL, 32'h4, 1'b1);
`else
    step();
    check_req("rb0.req0", 1'b1, 32'h0);
    serve("rb0.d0", NOP, 32'h0, 1'b0);
    step();
    check_req("rb0.req4", 1'b1, 32'h4);
    serve("rb0.d4", JAL, 32'h4, 1'b1);
`endif
    step();
    check_req("rb0.reqC", 1'b1, 32'hC);

    // Rollback to 0x100 with a simultaneous memory response: not delivered.
    rollback_from_rob = 1'b1; target_pc_from_rob = 32'h100;
    ok_flag_from_mc = 1'b1; inst_from_mc = 32'h00000093;
    step();
    rollback_from_rob = 1'b0; ok_flag_from_mc = 1'b0;
    check("rb100.ok", {31'h0, ok_flag_to_dsp}, 32'h0);
    check_req("rb100", 1'b0, 32'h0);
    check("rb100.qpc", query_pc, 32'h100);
    step();
    check_req("req100", 1'b1, 32'h100);

    // Queue full during a refill: delivery still completes, no new fetch.
    full_from_iq = 1'b1;
    serve("d100", NOP, 32'h100, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_req("full", 1'b0, 32'h0);
      check("full.ok", {31'h0, ok_flag_to_dsp}, 32'h0);
      check("full.qpc", query_pc, 32'h104);
    end
    full_from_iq = 1'b0;
    step();
    check_req("resume", 1'b1, 32'h104);

    // pc wraps from 0xFFFFFFFC to 0.
    rollback_from_rob = 1'b1; target_pc_from_rob = 32'hFFFF_FFFC;
    step();
    rollback_from_rob = 1'b0;
    check_req("rbtop", 1'b0, 32'h0);
    step();
    check_req("reqtop", 1'b1, 32'hFFFF_FFFC);
    serve("dtop", NOP, 32'hFFFF_FFFC, 1'b0);
    check("wrap.qpc", query_pc, 32'h0);

    // Reset in WAIT_MEM; cache valid bits must clear, so pc 0 misses.
    step(); step(); step();
    rst = 1'b1;
    step();
    check_req("rst2", 1'b0, 32'h0);
    check("rst2.ok", {31'h0, ok_flag_to_dsp}, 32'h0);
    check("rst2.inst", inst_to_dsp, 32'h0);
    check("rst2.pc", pc_to_dsp, 32'h0);
    rst = 1'b0;
    step();
    check_req("rst2.req", 1'b1, 32'h0);
    rst = 1'b1;
    step();
    check_req("rst3", 1'b0, 32'h0);
    check("rst3.qpc", query_pc, 32'h0);
    rst = 1'b0;
    step();
    check_req("rst3.req", 1'b1, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want end of test");
    $fatal(1, "watchdog");
  end

endmodule
